// File: rtl/data_memory_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_unit_if
// Description : Request/ready bus between the MIPS control/ALU side and the
//               data memory stage.
//               master : drives Req, MemRead, MemWrite, Address, WriteData
//               slave  : drives ReadData, Busy, Ready, AddrError
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Req;
  logic                  MemRead;
  logic                  MemWrite;
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Busy;
  logic                  Ready;
  logic                  AddrError;

  modport master (
    output Req, MemRead, MemWrite, Address, WriteData,
    input  ReadData, Busy, Ready, AddrError
  );

  modport slave (
    input  Req, MemRead, MemWrite, Address, WriteData,
    output ReadData, Busy, Ready, AddrError
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_unit
// Description : Word-indexed data memory with a programmable wait latency and
//               request/ready handshake. Address is a word index relative to
//               the data segment base.
// Ports       : clk   - clock, all state changes on the rising edge
//               reset - synchronous active-high reset
//               bus   - slave side of data_memory_unit_if
//                       (Req/MemRead/MemWrite/Address/WriteData in,
//                        ReadData/Busy/Ready/AddrError out)
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_unit #(
  parameter int MEMORY_DEPTH = 256,
  parameter int DATA_WIDTH   = 32,
  parameter int WAIT_CYCLES  = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  data_memory_unit_if.slave  bus
);

  localparam int c_ADDR_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int c_CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0]        c_DEPTH     = 32'(MEMORY_DEPTH);
  localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_ADDR_W-1:0]   r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_write;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_busy;
  logic                  r_ready;
  logic                  r_addr_err;

  // Storage is deliberately left out of reset so contents survive it.
  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

  logic w_accept;
  logic w_in_range;
  logic w_access;

  // Exactly one of MemRead/MemWrite qualifies a request.
  assign w_accept   = bus.Req & (bus.MemRead ^ bus.MemWrite);
  // Full 32-bit unsigned compare so large indices never alias into range.
  assign w_in_range = (bus.Address < c_DEPTH);
  // The access happens on the edge that ends the last WAIT cycle.
  assign w_access   = (r_state == S_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready    <= 1'b0;
          r_addr_err <= 1'b0;
          if (w_accept) begin
            r_addr     <= bus.Address[c_ADDR_W-1:0];
            r_wdata    <= bus.WriteData;
            r_is_write <= bus.MemWrite;
            if (w_in_range) begin
              r_state <= S_WAIT;
              r_cnt   <= c_WAIT_LOAD;
              r_busy  <= 1'b1;
            end else begin
              r_state    <= S_ERR;
              r_ready    <= 1'b1;
              r_addr_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (!r_is_write) begin
              r_rdata <= r_mem[r_addr];
            end
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_ready    <= 1'b0;
          r_addr_err <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Gating with reset discards a store whose access edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!reset && w_access && r_is_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign bus.ReadData  = r_rdata;
  assign bus.Busy      = r_busy;
  assign bus.Ready     = r_ready;
  assign bus.AddrError = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_unit
// Description : Self-checking bench for data_memory_unit. Two instances are
//               exercised: one with WAIT_CYCLES=2 (sel 0) and one with
//               WAIT_CYCLES=0 (sel 1), against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_memory_unit;
  localparam int DEPTH = 256;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic        mrd = 1'b0;
  logic        mwr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  data_memory_unit_if #(.DATA_WIDTH(DW)) bus_a ();
  data_memory_unit_if #(.DATA_WIDTH(DW)) bus_b ();

  assign bus_a.Req = req_a;   assign bus_b.Req = req_b;
  assign bus_a.MemRead = mrd; assign bus_b.MemRead = mrd;
  assign bus_a.MemWrite = mwr; assign bus_b.MemWrite = mwr;
  assign bus_a.Address = addr; assign bus_b.Address = addr;
  assign bus_a.WriteData = wdata; assign bus_b.WriteData = wdata;

  data_memory_unit #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  data_memory_unit #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  // Observed outputs of the instance currently under test.
  int          cur = 0;
  logic        o_busy, o_ready, o_aerr;
  logic [31:0] o_rd;
  always_comb begin
    o_busy = bus_a.Busy; o_ready = bus_a.Ready; o_aerr = bus_a.AddrError; o_rd = bus_a.ReadData;
    if (cur == 1) begin
      o_busy = bus_b.Busy; o_ready = bus_b.Ready; o_aerr = bus_b.AddrError; o_rd = bus_b.ReadData;
    end
  end

  // Reference model: memory image, which words are known, last load result.
  logic [31:0] m_mem   [2][DEPTH];
  bit          m_known [2][DEPTH];
  logic [31:0] m_rd    [2];
  int          m_wait  [2] = '{2, 0};

  int n_vec = 0;
  int n_err = 0;

  task automatic set_req(input bit v);
    if (cur == 0) req_a = v; else req_b = v;
  endtask

  // Entered and left on a falling edge. Issues one request in the current
  // cycle T, then checks every cycle up to one idle cycle after completion.
  // noise: 0 quiet, 1 random inputs while busy, 2 competing SW addr 7.
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input int noise, input string tag);
    int w;
    int last;
    bit inr;
    int idx;
    logic [2:0]  exp_ctl;
    logic [31:0] exp_rd;
    w    = m_wait[cur];
    inr  = (a < 32'(DEPTH));
    idx  = int'(a[7:0]);
    last = inr ? w + 3 : 2;
    set_req(1'b1); mwr = wr; mrd = !wr; addr = a; wdata = d;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_ctl[2] = inr && (k <= w + 1);
      exp_ctl[1] = inr ? (k == w + 2) : (k == 1);
      exp_ctl[0] = !inr && (k == 1);
      exp_rd = (inr && !wr && k >= w + 2) ? m_mem[cur][idx] : m_rd[cur];
      n_vec++;
      if ({o_busy, o_ready, o_aerr} !== exp_ctl) begin
        n_err++;
        $display("FAIL %s cyc+%0d busy/ready/aerr: got %b required %b", tag, k,
                 {o_busy, o_ready, o_aerr}, exp_ctl);
      end
      n_vec++;
      if (o_rd !== exp_rd) begin
        n_err++;
        $display("FAIL %s cyc+%0d ReadData: got %h required %h", tag, k, o_rd, exp_rd);
      end
      if (k < last && noise == 1) begin
        set_req(1'($urandom % 2)); mrd = 1'($urandom % 2); mwr = 1'($urandom % 2);
        addr = 32'($urandom_range(0, 300)); wdata = $urandom;
      end else if (k < last && noise == 2) begin
        set_req(1'b1); mrd = 1'b0; mwr = 1'b1; addr = 32'd7; wdata = 32'h2222_2222;
      end else begin
        set_req(1'b0); mrd = 1'b0; mwr = 1'b0;
      end
    end
    if (inr && !wr) m_rd[cur] = m_mem[cur][idx];
    if (inr && wr) begin
      m_mem[cur][idx]   = d;
      m_known[cur][idx] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus_a.Busy, bus_a.Ready, bus_a.AddrError, bus_a.ReadData} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_a: got %b/%b/%b/%h required 0", bus_a.Busy, bus_a.Ready,
               bus_a.AddrError, bus_a.ReadData);
    end
    n_vec++;
    if ({bus_b.Busy, bus_b.Ready, bus_b.AddrError, bus_b.ReadData} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_b: got %b/%b/%b/%h required 0", bus_b.Busy, bus_b.Ready,
               bus_b.AddrError, bus_b.ReadData);
    end
    m_rd[0] = '0; m_rd[1] = '0;
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    cur = 0;
    do_access(1'b1, 32'd5, 32'hDEAD_BEEF, 0, "sw5");
    do_access(1'b0, 32'd5, 32'h0, 0, "lw5");
  endtask

  task automatic test_out_of_range();
    cur = 0;
    do_access(1'b1, 32'd0, 32'h0BAD_0000, 0, "sw0");
    do_access(1'b0, 32'd256, 32'h0, 0, "lw256");
    do_access(1'b1, 32'd256, 32'h5555_AAAA, 0, "sw256");
    do_access(1'b1, 32'h105, 32'h6666_0000, 0, "sw105");
    do_access(1'b1, 32'hFFFF_FFFF, 32'h7777_0000, 0, "swmax");
    do_access(1'b0, 32'd0, 32'h0, 0, "lw0_after_oor");
    do_access(1'b0, 32'd5, 32'h0, 0, "lw5_after_oor");
  endtask

  task automatic test_input_stability();
    cur = 0;
    do_access(1'b1, 32'd7, 32'h7777_7777, 0, "sw7");
    do_access(1'b1, 32'd3, 32'h1111_1111, 2, "sw3_noisy");
    do_access(1'b0, 32'd3, 32'h0, 0, "lw3");
    do_access(1'b0, 32'd7, 32'h0, 0, "lw7");
  endtask

  task automatic test_reset_mid_wait();
    cur = 0;
    do_access(1'b1, 32'd9, 32'h1234_5678, 0, "sw9");
    set_req(1'b1); mwr = 1'b1; mrd = 1'b0; addr = 32'd9; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    n_vec++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid first_wait busy: got %b required 1", o_busy);
    end
    set_req(1'b0); mwr = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({o_busy, o_ready, o_aerr, o_rd} !== 35'd0) begin
        n_err++;
        $display("FAIL rst_mid outputs cyc%0d: got %b/%b/%b/%h required 0", k, o_busy,
                 o_ready, o_aerr, o_rd);
      end
      @(negedge clk);
    end
    do_access(1'b0, 32'd9, 32'h0, 0, "lw9_after_rst");
  endtask

  task automatic test_ignored();
    cur = 0;
    for (int k = 0; k < 8; k++) begin
      set_req(k < 7);
      mrd = (k < 5); mwr = (k < 5);
      addr = 32'd5; wdata = $urandom;
      @(negedge clk);
      n_vec++;
      if ({o_busy, o_ready, o_aerr} !== 3'b000) begin
        n_err++;
        $display("FAIL ignored_req cyc%0d: got %b required 000", k, {o_busy, o_ready, o_aerr});
      end
    end
    set_req(1'b0); mrd = 1'b0; mwr = 1'b0;
  endtask

  task automatic test_back_to_back();
    cur = 1;
    do_access(1'b1, 32'd20, 32'hCAFE_F00D, 0, "b2b_sw20");
    do_access(1'b0, 32'd20, 32'h0, 0, "b2b_lw20");
    do_access(1'b1, 32'd21, 32'h0123_4567, 0, "b2b_sw21");
    do_access(1'b0, 32'd21, 32'h0, 0, "b2b_lw21");
    do_access(1'b0, 32'd300, 32'h0, 0, "b2b_oor");
    do_access(1'b0, 32'd20, 32'h0, 1, "b2b_lw20_noisy");
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      cur = s;
      for (int t = 0; t < 30; t++) begin
        int r;
        int pick;
        logic [31:0] big;
        r = $urandom_range(0, 9);
        pick = -1;
        for (int tries = 0; tries < 64 && pick < 0; tries++) begin
          int c;
          c = $urandom_range(0, DEPTH - 1);
          if (m_known[cur][c]) pick = c;
        end
        if (r == 0) begin
          big = $urandom | 32'h0000_0100;
          do_access(1'($urandom % 2), big, $urandom, int'($urandom % 2), "rnd_oor");
        end else if (r < 5 || pick < 0) begin
          do_access(1'b1, 32'($urandom_range(0, DEPTH - 1)), $urandom,
                    int'($urandom % 2), "rnd_sw");
        end else begin
          do_access(1'b0, 32'(pick), 32'h0, int'($urandom % 2), "rnd_lw");
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) m_known[s][i] = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_input_stability();
    test_reset_mid_wait();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: got no completion by 500000ns, required finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
